bip_run_controller: RTL

Run/step/halt sequencer for the BIP core. Accepts host commands over a valid/ready handshake and drives the `start_bip` enable into the control block that holds the program counter, instruction decoder and PC ALU. Stops automatically on the HLT opcode and counts retired instructions. Publishes a halt report over a second valid/ready handshake, which the UART TX path consumes.

---
 rtl/bip_ctrl_pkg.sv | 19 +
 rtl/bip_sat_counter.sv | 31 +++
 rtl/bip_run_controller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bip_ctrl_pkg.sv
// Shared types and encodings for the BIP run/step/halt sequencer.
package bip_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_REPORT,
        S_HALT
    } state_e;

    localparam logic [1:0] CMD_RUN   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [4:0] OP_HLT = 5'b00000;

endpackage

// File: rtl/bip_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module bip_sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bip_run_controller.sv
// Run/step/halt sequencer for the BIP core with a handshaked halt report.
// Define BIP_STEP_EN to build single-step support; otherwise STEP is ignored.
module bip_run_controller
    import bip_ctrl_pkg::*;
#(
    parameter int AB = 11,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd,
    input  logic [4:0]    OpCode,
    input  logic [AB-1:0] Addr,
    output logic          start_bip,
    output logic          halted,
    output logic [CW-1:0] cycles,
    output logic [AB-1:0] halt_addr,
    output logic          rpt_valid,
    input  logic          rpt_ready,
    output logic          rpt_cause
);

    state_e        state_q, state_d;
    logic          cause_q, cause_d;
    logic [AB-1:0] addr_q, addr_d;
    logic          clr;
    logic          accept;
    logic          is_hlt;

    assign is_hlt = (OpCode == OP_HLT);
    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        addr_d    = addr_q;
        clr       = 1'b0;
        cmd_ready = 1'b0;
        start_bip = 1'b0;
        halted    = 1'b0;
        rpt_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    unique case (cmd)
                        CMD_RUN:   state_d = S_RUN;
`ifdef BIP_STEP_EN
                        CMD_STEP:  state_d = S_STEP;
`endif
                        CMD_CLEAR: clr = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cmd_ready = 1'b1;
                start_bip = !is_hlt;
                // HLT outranks a simultaneous STOP
                if (is_hlt) begin
                    state_d = S_REPORT;
                    cause_d = 1'b1;
                    addr_d  = Addr;
                end else if (accept && (cmd == CMD_STOP)) begin
                    state_d = S_REPORT;
                    cause_d = 1'b0;
                    addr_d  = Addr;
                end
            end
`ifdef BIP_STEP_EN
            S_STEP: begin
                start_bip = !is_hlt;
                state_d   = S_REPORT;
                cause_d   = is_hlt;
                addr_d    = Addr;
            end
`endif
            S_REPORT: begin
                rpt_valid = 1'b1;
                if (rpt_ready)
                    state_d = S_HALT;
            end
            S_HALT: begin
                cmd_ready = 1'b1;
                halted    = 1'b1;
                if (accept) begin
                    unique case (cmd)
                        CMD_RUN:   state_d = S_RUN;
`ifdef BIP_STEP_EN
                        CMD_STEP:  state_d = S_STEP;
`endif
                        CMD_CLEAR: begin
                            state_d = S_IDLE;
                            clr     = 1'b1;
                            addr_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cause_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            addr_q  <= addr_d;
        end
    end

    bip_sat_counter #(.CW(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .inc_i (start_bip),
        .cnt_o (cycles)
    );

    assign halt_addr = addr_q;
    assign rpt_cause = cause_q;

endmodule
